// File: rtl/sd_sector_responder.sv
// Host-side end of the core's sd_rd/sd_wr/sd_lba sector interface: it arbitrates the lanes,
// forwards one sector at a time to the SD backend and moves bytes to or from the core buffer.
module sd_sector_responder #(
  parameter int SECTOR_BYTES = 512,
  parameter int LANES        = 4,
  localparam int AW = $clog2(SECTOR_BYTES),
  localparam int LW = $clog2(LANES),
  localparam int CW = AW + 1
) (
  input  logic             clk_32,
  input  logic             resb,
  input  logic [31:0]      sd_lba,
  input  logic [LANES-1:0] sd_rd,
  input  logic [LANES-1:0] sd_wr,
  output logic             sd_busy,
  output logic             sd_done,
  output logic [AW-1:0]    sd_buff_addr,
  output logic [7:0]       sd_dout,
  output logic             sd_dout_strobe,
  input  logic [7:0]       sd_din,
  output logic [LW-1:0]    active_lane,
  output logic             sdc_rd,
  output logic             sdc_wr,
  output logic [31:0]      sdc_lba,
  input  logic             sdc_busy,
  input  logic             sdc_done,
  input  logic [7:0]       sdc_rbyte,
  input  logic             sdc_rbyte_strb,
  output logic [7:0]       sdc_wbyte,
  input  logic             sdc_wbyte_req
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;
  logic          dir_wr;
  logic          preload;
  logic          any_req;
  logic [LW-1:0] win_lane;
  logic          win_rd;
  logic          full;
  logic          rd_take;
  logic          wr_take;
  logic          fin;

  // Scan from the top down so that the lowest requesting lane is the one left in win_lane.
  always_comb begin
    any_req  = 1'b0;
    win_lane = '0;
    win_rd   = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (sd_rd[i] | sd_wr[i]) begin
        any_req  = 1'b1;
        win_lane = LW'(i);
        win_rd   = sd_rd[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = REQ;
      REQ: begin
        if (sdc_done)      state_nxt = DONE;
        else if (sdc_busy) state_nxt = XFER;
      end
      XFER: if (sdc_done) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_32 or negedge resb) begin
    if (!resb) state <= IDLE;
    else       state <= state_nxt;
  end

  assign count_inc = count + 1'b1;
  assign full      = (count == CW'(SECTOR_BYTES));
  assign rd_take   = (state == XFER) && !dir_wr && sdc_rbyte_strb && !full;
  // count leads the backend by one byte on writes: the preload fetches byte 0 and every request
  // fetches the following one, so sd_din for the next request is already settled.
  assign wr_take   = (state == XFER) && dir_wr && (preload || sdc_wbyte_req) && !full;
  assign fin       = ((state == REQ) || (state == XFER)) && sdc_done;

  always_ff @(posedge clk_32 or negedge resb) begin
    if (!resb) begin
      sd_busy        <= 1'b0;
      sd_done        <= 1'b0;
      sd_buff_addr   <= '0;
      sd_dout        <= '0;
      sd_dout_strobe <= 1'b0;
      active_lane    <= '0;
      sdc_rd         <= 1'b0;
      sdc_wr         <= 1'b0;
      sdc_lba        <= '0;
      sdc_wbyte      <= '0;
      count          <= '0;
      dir_wr         <= 1'b0;
      preload        <= 1'b0;
    end else begin
      sd_dout_strobe <= 1'b0;
      sd_done        <= 1'b0;
      preload        <= (state == REQ) && sdc_busy && !sdc_done && dir_wr;

      if ((state == IDLE) && any_req) begin
        sdc_lba      <= sd_lba;
        active_lane  <= win_lane;
        dir_wr       <= !win_rd;
        count        <= '0;
        sd_buff_addr <= '0;
        sdc_rd       <= win_rd;
        sdc_wr       <= !win_rd;
        sd_busy      <= 1'b1;
      end

      if ((state == REQ) && (sdc_busy || sdc_done)) begin
        sdc_rd <= 1'b0;
        sdc_wr <= 1'b0;
      end

      if (rd_take) begin
        sd_dout        <= sdc_rbyte;
        sd_dout_strobe <= 1'b1;
        sd_buff_addr   <= count[AW-1:0];
        count          <= count_inc;
      end

      if (wr_take) begin
        sdc_wbyte    <= sd_din;
        sd_buff_addr <= count_inc[AW-1:0];
        count        <= count_inc;
      end

      // A byte arriving together with sdc_done keeps its address for the final strobe.
      if (fin) begin
        sd_done <= 1'b1;
        sd_busy <= 1'b0;
        count   <= '0;
        if (!rd_take) sd_buff_addr <= '0;
      end

      if (state == DONE) sd_buff_addr <= '0;
    end
  end

  a_done_not_busy: assert property (@(posedge clk_32) disable iff (!resb) sd_done |-> !sd_busy);
  a_one_request:   assert property (@(posedge clk_32) disable iff (!resb) !(sdc_rd && sdc_wr));
  a_strobe_read:   assert property (@(posedge clk_32) disable iff (!resb) sd_dout_strobe |-> !dir_wr);

endmodule
